// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with PC, req/ready imem port, one-entry hold buffer and IF/ID register.
// Optional performance counters are enabled by defining IF_FETCH_PERF_EN.
module if_fetch_stage #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc4
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     target_q, target_d;
  logic [INSTR_W-1:0]  hold_instr_q, hold_instr_d;
  logic [PC_W-1:0]     hold_pc4_q, hold_pc4_d;
  logic                ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0]  ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]     ifid_pc4_q, ifid_pc4_d;
  logic                ifid_load, ifid_bubble;
  logic                xfer;
  logic [PC_W-1:0]     pc_plus4;

  // In DRAIN the PC still holds the killed request's address, so imem_addr is always pc.
  assign imem_addr  = pc_q;
  assign imem_req   = !rst && (state_q != StHold);
  assign xfer       = imem_req && imem_ready;
  assign pc_plus4   = pc_q + PC_W'(4);
  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    target_d     = target_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;

    if (redirect) begin
      ifid_bubble  = 1'b1;
      hold_instr_d = '0;
      hold_pc4_d   = '0;
      unique case (state_q)
        StFetch: begin
          if (xfer) begin
            pc_d = redirect_pc;
          end else begin
            target_d = redirect_pc;
            state_d  = StDrain;
          end
        end
        StHold: begin
          pc_d    = redirect_pc;
          state_d = StFetch;
        end
        StDrain: begin
          if (xfer) begin
            pc_d    = redirect_pc;
            state_d = StFetch;
          end else begin
            target_d = redirect_pc;
          end
        end
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (xfer) begin
            pc_d = pc_plus4;
            if (stall) begin
              hold_instr_d = imem_rdata;
              hold_pc4_d   = pc_plus4;
              state_d      = StHold;
            end else begin
              ifid_load    = 1'b1;
              ifid_instr_d = imem_rdata;
              ifid_pc4_d   = pc_plus4;
            end
          end else if (!stall) begin
            ifid_bubble = 1'b1;
          end
        end
        StHold: begin
          if (!stall) begin
            ifid_load    = 1'b1;
            ifid_instr_d = hold_instr_q;
            ifid_pc4_d   = hold_pc4_q;
            state_d      = StFetch;
          end
        end
        StDrain: begin
          // Returned data belongs to the killed path and is dropped.
          ifid_bubble = 1'b1;
          if (xfer) begin
            pc_d    = target_q;
            state_d = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end

    ifid_valid_d = ifid_valid_q;
    if (ifid_bubble) ifid_valid_d = 1'b0;
    if (ifid_load)   ifid_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      target_q     <= '0;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      target_q     <= target_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (ifid_load)   fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (ifid_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule
